// File: rtl/adder_operand_loader.sv
// Byte-stream loader for the 32-bit ripple adder: assembles A, B and carry-in from a 9-byte frame.
// Optional inter-byte idle timeout is built in when ADDER_LOADER_TIMEOUT_EN is defined.
module adder_operand_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic        cin,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [3:0]  byte_cnt,
  output logic        err_timeout
);

  typedef enum logic {LOAD, HOLD} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  byte_cnt_reg, byte_cnt_next;
  logic [31:0] a_reg, a_next, b_reg, b_next;
  logic        cin_reg, cin_next;
  logic        op_valid_reg, op_valid_next;
  logic        in_ready_reg, in_ready_next;
  logic [31:0] shadow_a, shadow_b;
  logic        xfer;
  logic        timeout_fire;

  assign xfer = in_valid && in_ready_reg;

  // Each byte lane of the shadow operands captures its own frame position.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_a_reg, lane_b_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          lane_a_reg <= '0;
          lane_b_reg <= '0;
        end else if (xfer) begin
          if (byte_cnt_reg == 4'(gi))     lane_a_reg <= in_data;
          if (byte_cnt_reg == 4'(gi + 4)) lane_b_reg <= in_data;
        end
      end
      assign shadow_a[8*gi +: 8] = lane_a_reg;
      assign shadow_b[8*gi +: 8] = lane_b_reg;
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    byte_cnt_next = byte_cnt_reg;
    a_next        = a_reg;
    b_next        = b_reg;
    cin_next      = cin_reg;
    op_valid_next = op_valid_reg;
    in_ready_next = in_ready_reg;
    case (state_reg)
      LOAD: begin
        in_ready_next = 1'b1;
        if (xfer) begin
          if (byte_cnt_reg == 4'd8) begin
            byte_cnt_next = '0;
            a_next        = shadow_a;
            b_next        = shadow_b;
            cin_next      = in_data[0];
            op_valid_next = 1'b1;
            in_ready_next = 1'b0;
            state_next    = HOLD;
          end else begin
            byte_cnt_next = byte_cnt_reg + 4'd1;
          end
        end else if (timeout_fire) begin
          byte_cnt_next = '0;
        end
      end
      HOLD: begin
        if (op_valid_reg && op_ready) begin
          op_valid_next = 1'b0;
          in_ready_next = 1'b1;
          state_next    = LOAD;
        end
      end
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= LOAD;
      byte_cnt_reg <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      cin_reg      <= 1'b0;
      op_valid_reg <= 1'b0;
      in_ready_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      byte_cnt_reg <= byte_cnt_next;
      a_reg        <= a_next;
      b_reg        <= b_next;
      cin_reg      <= cin_next;
      op_valid_reg <= op_valid_next;
      in_ready_reg <= in_ready_next;
    end
  end

`ifdef ADDER_LOADER_TIMEOUT_EN
  localparam int IW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [IW-1:0] idle_reg;
  logic          err_timeout_reg;

  // A coinciding transfer always wins over the timeout.
  assign timeout_fire = (state_reg == LOAD) && (byte_cnt_reg != 4'd0) && !xfer &&
                        (idle_reg == IW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_reg        <= '0;
      err_timeout_reg <= 1'b0;
    end else begin
      err_timeout_reg <= timeout_fire;
      if (xfer || (state_reg != LOAD) || timeout_fire)
        idle_reg <= '0;
      else if (byte_cnt_reg != 4'd0)
        idle_reg <= idle_reg + IW'(1);
    end
  end

  assign err_timeout = err_timeout_reg;
`else
  assign timeout_fire = 1'b0;
  // The idle limit only matters when the timeout is built in.
  assign err_timeout  = 1'b0 && (TIMEOUT_CYCLES >= 2);
`endif

  assign in_ready = in_ready_reg;
  assign a        = a_reg;
  assign b        = b_reg;
  assign cin      = cin_reg;
  assign op_valid = op_valid_reg;
  assign byte_cnt = byte_cnt_reg;

endmodule

// File: doc/adder_operand_loader.md
Name: adder_operand_loader

Overview:
- Upstream stage for the 32-bit ripple adder. Assembles operands A, B and carry-in from a byte-wide valid/ready stream, such as a UART receiver or a test sequencer.
- Presents registered, stable a/b/cin to the combinational adder. Holds them with op_valid until the downstream result checker accepts them.
- Decouples the slow byte source from the adder/checker; one operand set is in flight at a time.

Parameters:
- TIMEOUT_CYCLES, 1000000, inter-byte idle limit in clk cycles. Used only when ADDER_LOADER_TIMEOUT_EN is defined; must be >= 2.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_data  in  8  operand byte stream
- in_valid  in  1  in_data valid
- in_ready  out  1  loader can accept a byte
- a  out  32  operand A to adder
- b  out  32  operand B to adder
- cin  out  1  carry-in to adder
- op_valid  out  1  a/b/cin complete and stable
- op_ready  in  1  downstream has consumed the operand set
- byte_cnt  out  4  bytes received in current frame, 0..8
- err_timeout  out  1  one-cycle pulse when a partial frame is dropped

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: state=LOAD, byte_cnt=0, a=0, b=0, cin=0, op_valid=0, in_ready=0, err_timeout=0, shadow registers=0.
- in_ready is registered. It is 0 during reset and goes to 1 on the first clk edge after rst_n deasserts, while state=LOAD.
- A byte transfer occurs on a rising edge when in_valid && in_ready.
- Frame is 9 bytes:
  - byte k (0..3) -> shadow_a[8k+7:8k], little-endian.
  - byte k (4..7) -> shadow_b[8(k-4)+7:8(k-4)].
  - byte 8: bit0 -> cin; bits 7:1 are ignored.
- byte_cnt increments on each transfer, 0->8. On the byte-8 transfer it returns to 0.
- States:
  - LOAD: accepts bytes. On the byte-8 transfer, a<=shadow_a, b<=shadow_b, cin<=in_data[0], op_valid<=1, in_ready<=0, next state HOLD. All of these take effect in the same edge.
  - HOLD: a/b/cin/op_valid are frozen and no bytes are accepted. On an edge with op_valid && op_ready: op_valid<=0, in_ready<=1, next state LOAD.
- a/b/cin change only on the byte-8 transfer. They keep their last values after the handshake until the next frame completes.
- op_ready may already be high when op_valid rises. Consumption then happens on the next edge, so minimum HOLD is 1 cycle.
- Latency: op_valid is high the cycle after the final byte is accepted. The next byte is accepted no earlier than 1 cycle after the op handshake. Max throughput is 1 frame per 10 cycles.
- in_valid while in_ready=0 is ignored; the byte is not consumed.
- rst_n asserted mid-frame or mid-HOLD: everything returns to reset values immediately and the partial frame is discarded.
- Without the timeout feature, err_timeout is tied 0.

Optional Feature:
- Macro: ADDER_LOADER_TIMEOUT_EN.
- Defined:
  - An idle counter clears on every transfer and when state != LOAD.
  - It increments each cycle in LOAD while byte_cnt != 0 and no transfer occurs.
  - When it reaches TIMEOUT_CYCLES-1: byte_cnt<=0, shadow regs are kept but will be overwritten, err_timeout pulses 1 for one cycle, and the idle counter clears.
  - a/b/cin/op_valid are unaffected.
  - A timeout coinciding with a transfer does not fire; the transfer wins.
- Undefined: no counter logic; a partial frame waits indefinitely; err_timeout=0.

Test Plan:
- Reset release, then bytes 01 00 00 00 02 00 00 00 00 -> op_valid=1 one cycle after the 9th byte; a=0x00000001, b=0x00000002, cin=0; adder sum=0x00000003.
- Frame FF FF FF FF 01 00 00 00 FF with op_ready=1 -> a=0xFFFFFFFF, b=1, cin=1 (bits 7:1 ignored); op_valid high exactly 1 cycle; in_ready=1 the cycle after; sum=0x00000001, cout=1.
- Hold op_ready=0 for 20 cycles with in_valid driven high (data AA) -> in_ready=0, a/b/cin unchanged, no bytes consumed. Raise op_ready -> handshake; the next AA byte is accepted as byte 0.
- Assert rst_n=0 asynchronously after byte 5 -> all outputs 0 immediately, byte_cnt=0. A full new frame 10 00 00 00 20 00 00 00 01 -> a=0x10, b=0x20, cin=1.
- With ADDER_LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=16: send 3 bytes, then idle -> err_timeout pulses once, 16 cycles after the last transfer, and byte_cnt=0. The next 9-byte frame loads correctly. Without the macro: no pulse; completing the remaining 6 bytes yields a valid frame.
